// File: rtl/flexcim_pkg.sv
// Shared flexcim constants: psum accumulator FSM encoding and saturating-add widths.
package flexcim_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One extra sum bit is enough to see a signed overflow of two ACC_WIDTH operands.
  localparam int SAT_GUARD_BITS = 1;

  localparam int DEF_ODATA_WIDTH_FINAL = 22;
  localparam int DEF_ACC_WIDTH         = 32;

endpackage

// File: rtl/sat_add_col.sv
// One psum column: sign-extend the incoming value, then either load it or add it
// to the running accumulator with signed saturation.
module sat_add_col
  import flexcim_pkg::*;
#(
  parameter int IN_W  = DEF_ODATA_WIDTH_FINAL,
  parameter int ACC_W = DEF_ACC_WIDTH
) (
  input  logic             load,
  input  logic [IN_W-1:0]  col,
  input  logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] result
);

  localparam int SUM_W = ACC_W + SAT_GUARD_BITS;

  logic [SUM_W-1:0] col_ext;
  logic [SUM_W-1:0] acc_ext;
  logic [SUM_W-1:0] sum;

  assign col_ext = {{(SUM_W-IN_W){col[IN_W-1]}}, col};
  assign acc_ext = {{SAT_GUARD_BITS{acc[ACC_W-1]}}, acc};
  assign sum     = acc_ext + col_ext;

  // Overflow shows up as the guard bit disagreeing with the ACC_W sign bit.
  always_comb begin
    result = sum[ACC_W-1:0];
    if (load) begin
      result = col_ext[ACC_W-1:0];
    end else if (sum[SUM_W-1] != sum[ACC_W-1]) begin
      result = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a job of psum tiles column-wise, then drains one column per
// handshake in index order and pulses o_done after the last column.
module psum_accumulator
  import flexcim_pkg::*;
#(
  parameter int NUM_COLS          = 32,
  parameter int ODATA_WIDTH_FINAL = DEF_ODATA_WIDTH_FINAL,
  parameter int ACC_WIDTH         = DEF_ACC_WIDTH,
  parameter int TILE_CNT_W        = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_start,
  input  logic [TILE_CNT_W-1:0]             i_num_tiles,
  input  logic                              i_psum_valid,
  input  logic [NUM_COLS*ODATA_WIDTH_FINAL-1:0] i_psum_final,
  output logic                              o_psum_ready,
  output logic                              o_valid,
  output logic [$clog2(NUM_COLS)-1:0]       o_col_idx,
  output logic [ACC_WIDTH-1:0]              o_data,
  input  logic                              i_ready,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [1:0]                        dbg_state
);

  localparam int COL_W = $clog2(NUM_COLS);

  logic [1:0]            state;
  logic [TILE_CNT_W-1:0] tiles_lat;
  logic [TILE_CNT_W-1:0] tile_cnt;
  logic [TILE_CNT_W-1:0] tile_cnt_nxt;
  logic [COL_W-1:0]      col_idx;
  logic                  done_q;
  logic                  accept;
  logic                  drain_hs;
  logic                  last_col;
  logic [ACC_WIDTH-1:0]  acc     [NUM_COLS];
  logic [ACC_WIDTH-1:0]  acc_nxt [NUM_COLS];

  // Both ports use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; the source holds its word until that edge.
  assign o_psum_ready = (state == ST_ACCUM);
  assign accept       = i_psum_valid && o_psum_ready;
  assign o_valid      = (state == ST_DRAIN);
  assign drain_hs     = o_valid && i_ready;
  assign last_col     = (col_idx == COL_W'(NUM_COLS - 1));
  assign tile_cnt_nxt = tile_cnt + TILE_CNT_W'(1);

  assign o_busy    = (state != ST_IDLE);
  assign o_done    = done_q;
  assign o_col_idx = col_idx;
  assign o_data    = acc[col_idx];
  assign dbg_state = state;

  for (genvar c = 0; c < NUM_COLS; c++) begin : gen_col
    sat_add_col #(
      .IN_W  (ODATA_WIDTH_FINAL),
      .ACC_W (ACC_WIDTH)
    ) u_sat_add_col (
      .load   (tile_cnt == '0),
      .col    (i_psum_final[c*ODATA_WIDTH_FINAL +: ODATA_WIDTH_FINAL]),
      .acc    (acc[c]),
      .result (acc_nxt[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tiles_lat <= '0;
      tile_cnt  <= '0;
      col_idx   <= '0;
      done_q    <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) acc[c] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            // A zero tile count would never complete, so it runs as a single tile.
            tiles_lat <= (i_num_tiles == '0) ? TILE_CNT_W'(1) : i_num_tiles;
            tile_cnt  <= '0;
            state     <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            for (int c = 0; c < NUM_COLS; c++) acc[c] <= acc_nxt[c];
            tile_cnt <= tile_cnt_nxt;
            if (tile_cnt_nxt == tiles_lat) begin
              col_idx <= '0;
              state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_hs) begin
            if (last_col) begin
              col_idx <= '0;
              done_q  <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              col_idx <= col_idx + COL_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: one instance at the default 32-bit
// accumulator and one at 22 bits for saturation, both fed the same stimulus.
module tb_psum_accumulator;
  import flexcim_pkg::*;

  localparam int NC   = 32;
  localparam int OW   = 22;
  localparam int TW   = 8;
  localparam int CW   = 5;
  localparam int AW_B = 22;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [TW-1:0]     i_num_tiles = '0;
  logic              i_psum_valid = 1'b0;
  logic [NC*OW-1:0]  i_psum_final = '0;
  logic              i_ready = 1'b0;

  logic              psum_ready_a, valid_a, busy_a, done_a;
  logic [CW-1:0]     col_idx_a;
  logic [31:0]       data_a;
  logic [1:0]        state_a;
  logic              psum_ready_b, valid_b, busy_b, done_b;
  logic [CW-1:0]     col_idx_b;
  logic [AW_B-1:0]   data_b;
  logic [1:0]        state_b;

  int n_checks = 0;
  int n_errors = 0;
  int exp_a [NC];
  int exp_b [NC];

  always #5 clk = ~clk;

  psum_accumulator #(
    .NUM_COLS(NC), .ODATA_WIDTH_FINAL(OW), .ACC_WIDTH(32), .TILE_CNT_W(TW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_tiles(i_num_tiles),
    .i_psum_valid(i_psum_valid), .i_psum_final(i_psum_final),
    .o_psum_ready(psum_ready_a), .o_valid(valid_a), .o_col_idx(col_idx_a),
    .o_data(data_a), .i_ready(i_ready), .o_busy(busy_a), .o_done(done_a),
    .dbg_state(state_a)
  );

  psum_accumulator #(
    .NUM_COLS(NC), .ODATA_WIDTH_FINAL(OW), .ACC_WIDTH(AW_B), .TILE_CNT_W(TW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_tiles(i_num_tiles),
    .i_psum_valid(i_psum_valid), .i_psum_final(i_psum_final),
    .o_psum_ready(psum_ready_b), .o_valid(valid_b), .o_col_idx(col_idx_b),
    .o_data(data_b), .i_ready(i_ready), .o_busy(busy_b), .o_done(done_b),
    .dbg_state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
               tag, $signed(got), got, $signed(want), want, $time);
    end
  endtask

  function automatic logic [31:0] sext_b(input logic [AW_B-1:0] v);
    return {{(32-AW_B){v[AW_B-1]}}, v};
  endfunction

  function automatic logic [NC*OW-1:0] tile_from(input int vals [NC]);
    logic [NC*OW-1:0] t;
    int v;
    t = '0;
    for (int c = 0; c < NC; c++) begin
      v = vals[c];
      t[c*OW +: OW] = v[OW-1:0];
    end
    return t;
  endfunction

  function automatic logic [NC*OW-1:0] tile_const(input int v);
    int vals [NC];
    for (int c = 0; c < NC; c++) vals[c] = v;
    return tile_from(vals);
  endfunction

  task automatic set_exp_const(input int a, input int b);
    for (int c = 0; c < NC; c++) begin
      exp_a[c] = a;
      exp_b[c] = b;
    end
  endtask

  // Called at a negedge; i_start is seen by the following rising edge.
  task automatic start_job(input int n);
    i_start = 1'b1;
    i_num_tiles = n[TW-1:0];
    @(negedge clk);
    i_start = 1'b0;
    check("start_busy", busy_a, 1);
    check("start_state", state_a, ST_ACCUM);
    check("start_psum_ready", psum_ready_a, 1);
    check("done_one_cycle", done_a, 0);
  endtask

  task automatic send_tile(input logic [NC*OW-1:0] t);
    int k;
    k = 0;
    i_psum_final = t;
    i_psum_valid = 1'b1;
    while (!psum_ready_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tile_ready", psum_ready_a, 1);
    @(negedge clk);
    i_psum_valid = 1'b0;
  endtask

  // Entered at the negedge after the last tile was taken; returns in the o_done cycle.
  task automatic drain_check(input bit rnd, input bit offer_tile);
    int col;
    int cyc;
    bit stalled;
    logic [31:0] held_data;
    logic [CW-1:0] held_idx;
    col = 0;
    cyc = 0;
    stalled = 1'b0;
    held_data = '0;
    held_idx = '0;
    if (offer_tile) begin
      i_psum_final = tile_const(500);
      i_psum_valid = 1'b1;
    end
    while (col < NC && cyc < 400) begin
      if (stalled) begin
        check("stall_data", data_a, held_data);
        check("stall_idx", col_idx_a, held_idx);
      end
      check("drain_valid", valid_a, 1);
      check("drain_psum_ready", psum_ready_a, 0);
      check("drain_idx", col_idx_a, col);
      check("drain_data_a", data_a, exp_a[col]);
      check("drain_data_b", sext_b(data_b), exp_b[col]);
      check("drain_no_done", done_a, 0);
      i_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      stalled = !i_ready;
      held_data = data_a;
      held_idx = col_idx_a;
      if (i_ready) col++;
      cyc++;
      @(negedge clk);
    end
    i_ready = 1'b0;
    i_psum_valid = 1'b0;
    check("drain_all_cols", col, NC);
    check("done_pulse_a", done_a, 1);
    check("done_pulse_b", done_b, 1);
    check("done_valid_low", valid_a, 0);
    check("done_busy_low", busy_a, 0);
    check("done_state_idle", state_a, ST_IDLE);
  endtask

  initial begin
    int vals [NC];
    int vals2 [NC];
    int k;

    // Reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", valid_a, 0);
    check("rst_done", done_a, 0);
    check("rst_psum_ready", psum_ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_col_idx", col_idx_a, 0);
    check("rst_data", data_a, 0);
    check("rst_state", state_a, ST_IDLE);

    // Three tiles 5, 7, -2 -> 10 everywhere
    start_job(3);
    send_tile(tile_const(5));
    check("mid_accum_no_valid", valid_a, 0);
    send_tile(tile_const(7));
    send_tile(tile_const(-2));
    set_exp_const(10, 10);
    drain_check(1'b0, 1'b0);

    // Back-to-back: zero tile count runs one tile, column c carries c
    for (int c = 0; c < NC; c++) begin
      vals[c] = c;
      exp_a[c] = c;
      exp_b[c] = c;
    end
    start_job(0);
    send_tile(tile_from(vals));
    drain_check(1'b0, 1'b0);

    // Saturation: even columns at +2^21-1, odd at -2^21, two tiles each
    for (int c = 0; c < NC; c++) begin
      vals[c]  = (c % 2 == 0) ? 2097151 : -2097152;
      exp_a[c] = (c % 2 == 0) ? 4194302 : -4194304;
      exp_b[c] = (c % 2 == 0) ? 2097151 : -2097152;
    end
    @(negedge clk);
    check("idle_done_low", done_a, 0);
    start_job(2);
    send_tile(tile_from(vals));
    send_tile(tile_from(vals));
    drain_check(1'b0, 1'b0);

    // Random downstream stalls: c-16 then 100*c -> 101*c-16
    for (int c = 0; c < NC; c++) begin
      vals[c]  = c - 16;
      vals2[c] = 100 * c;
      exp_a[c] = 101 * c - 16;
      exp_b[c] = 101 * c - 16;
    end
    @(negedge clk);
    start_job(2);
    send_tile(tile_from(vals));
    send_tile(tile_from(vals2));
    drain_check(1'b1, 1'b0);

    // Tiles offered in IDLE/DRAIN are refused; i_start inside ACCUM is ignored
    @(negedge clk);
    i_psum_final = tile_const(99);
    i_psum_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("idle_psum_ready", psum_ready_a, 0);
      check("idle_busy", busy_a, 0);
      @(negedge clk);
    end
    i_psum_valid = 1'b0;
    start_job(2);
    send_tile(tile_const(3));
    i_start = 1'b1;
    i_num_tiles = 8'd1;
    @(negedge clk);
    i_start = 1'b0;
    check("accum_start_ignored", state_a, ST_ACCUM);
    check("accum_still_ready", psum_ready_a, 1);
    send_tile(tile_const(4));
    set_exp_const(7, 7);
    drain_check(1'b0, 1'b1);

    // Reset in the middle of a drain, then a fresh job
    for (int c = 0; c < NC; c++) vals[c] = 1000 + c;
    @(negedge clk);
    start_job(1);
    send_tile(tile_from(vals));
    i_ready = 1'b1;
    k = 0;
    while (col_idx_a != CW'(10) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_col", col_idx_a, 10);
    check("rst_mid_data", data_a, 1010);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b0;
    check("abort_valid", valid_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_data", data_a, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", done_a, 0);
      @(negedge clk);
    end
    start_job(2);
    send_tile(tile_const(1));
    send_tile(tile_const(2));
    set_exp_const(3, 3);
    drain_check(1'b1, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
